// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus bundle: peripheral source lines, the CPU request/ack
// handshake and the small register port.
//   master : the interrupt controller (drives int_req, int_vector, reg_rdata)
//   slave  : the core / peripherals / register host (drive everything else)
interface interrupt_controller_if #(
    parameter int NUM_SOURCES = 4
);
    logic [NUM_SOURCES-1:0] irq_in;
    logic                   int_req;
    logic [7:0]             int_vector;
    logic                   int_ack;
    logic                   int_done;
    logic                   reg_we;
    logic [1:0]             reg_addr;
    logic [7:0]             reg_wdata;
    logic [7:0]             reg_rdata;

    modport master (
        input  irq_in, int_ack, int_done, reg_we, reg_addr, reg_wdata,
        output int_req, int_vector, reg_rdata
    );

    modport slave (
        output irq_in, int_ack, int_done, reg_we, reg_addr, reg_wdata,
        input  int_req, int_vector, reg_rdata
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: rising-edge sources are latched into pending, masked by
// enable, and the lowest-index candidate is presented to the core as int_req +
// int_vector. The request is held until int_ack, then the controller waits in
// service until int_done (RETI) before arbitrating again. No nesting.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : interrupt_controller_if.master (irq_in, int_req, int_vector,
//                int_ack, int_done, reg_we/addr/wdata, reg_rdata)
// Registers: 0 enable (R/W), 1 pending (R, W1C),
//            2 status {in_service, req_active, 3'b0, active_id}, 3 sw trigger (W1S)
module interrupt_controller #(
    parameter int          NUM_SOURCES   = 4,
    parameter logic [7:0]  VECTOR_BASE   = 8'h80,
    parameter logic [7:0]  VECTOR_STRIDE = 8'h04
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_controller_if.master bus
);
    localparam int NS = NUM_SOURCES;

    typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE} state_t;

    state_t          state_q;
    logic [NS-1:0]   enable_q, pending_q, irq_prev_q;
    logic [2:0]      active_id_q;
    logic            int_req_q;
    logic [7:0]      int_vector_q;

    logic [NS-1:0]   rise, sw_set, w1c, ack_clr, active_oh;
    logic [NS-1:0]   enable_d, pending_d, cand;
    logic [2:0]      cand_id;
    logic [7:0]      cand_vec;
    logic            ack_now, withdraw;
    logic            unused_wdata;

    assign unused_wdata = ^bus.reg_wdata;

    always_comb begin
        rise     = bus.irq_in & ~irq_prev_q;
        sw_set   = (bus.reg_we && bus.reg_addr == 2'd3) ? bus.reg_wdata[NS-1:0] : '0;
        w1c      = (bus.reg_we && bus.reg_addr == 2'd1) ? bus.reg_wdata[NS-1:0] : '0;
        enable_d = (bus.reg_we && bus.reg_addr == 2'd0) ? bus.reg_wdata[NS-1:0] : enable_q;

        for (int i = 0; i < NS; i++) active_oh[i] = (active_id_q == 3'(i));

        ack_now  = (state_q == REQUEST) && bus.int_ack;
        ack_clr  = ack_now ? active_oh : '0;
        // Any set source beats any clear source in the same cycle.
        pending_d = (pending_q & ~(w1c | ack_clr)) | rise | sw_set;

        // Withdraw looks at next-cycle pending/enable so a clear or mask write
        // drops int_req on the very next edge.
        withdraw = ~|(pending_d & enable_d & active_oh);

        cand    = pending_q & enable_q;
        cand_id = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (cand[i]) cand_id = 3'(i);
        end
        cand_vec = VECTOR_BASE + {5'b0, cand_id} * VECTOR_STRIDE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            enable_q     <= '0;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            active_id_q  <= '0;
            int_req_q    <= 1'b0;
            int_vector_q <= VECTOR_BASE;
        end else begin
            irq_prev_q <= bus.irq_in;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        active_id_q  <= cand_id;
                        int_vector_q <= cand_vec;
                        int_req_q    <= 1'b1;
                        state_q      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (ack_now) begin
                        int_req_q <= 1'b0;
                        state_q   <= IN_SERVICE;
                    end else if (withdraw) begin
                        int_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                IN_SERVICE: begin
                    if (bus.int_done) state_q <= IDLE;
                end
                default: begin
                    int_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            2'd0:    bus.reg_rdata[NS-1:0] = enable_q;
            2'd1:    bus.reg_rdata[NS-1:0] = pending_q;
            2'd2:    bus.reg_rdata = {state_q == IN_SERVICE, state_q == REQUEST, 3'b000, active_id_q};
            default: bus.reg_rdata = '0;
        endcase
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vector = int_vector_q;
endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];   // expected vectors, in order of request

    interrupt_controller_if #(.NUM_SOURCES(4)) bus();

    interrupt_controller #(
        .NUM_SOURCES(4), .VECTOR_BASE(8'h80), .VECTOR_STRIDE(8'h04)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
        step();
        bus.reg_we = 1'b0; bus.reg_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    task automatic pulse_irq(input logic [3:0] m);
        bus.irq_in = bus.irq_in | m;
        step();
        bus.irq_in = bus.irq_in & ~m;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1; step(); bus.int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.int_done = 1'b1; step(); bus.int_done = 1'b0;
    endtask

    // Bounded wait for int_req; ok=0 on timeout.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.int_req === 1'b1) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        step(2);
        reset = 1'b0;
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", bus.int_req); end
        checks++; if (bus.int_vector !== 8'h80) begin failures++; $display("FAIL reset_vec got=%h want=80", bus.int_vector); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h want=00", a, d); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] d, e;
        wr(2'd0, 8'h01);
        sb.push_back(8'h80);
        pulse_irq(4'b0001);
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL basic_early got=%b want=0", bus.int_req); end
        step();
        checks++; if (bus.int_req !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b want=1", bus.int_req); end
        e = sb.pop_front();
        checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL basic_vec got=%h want=%h", bus.int_vector, e); end
        pulse_ack();
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL basic_ack got=%b want=0", bus.int_req); end
        rd(2'd2, d);
        checks++; if (d !== 8'h80) begin failures++; $display("FAIL basic_status_srv got=%h want=80", d); end
        pulse_done();
        rd(2'd2, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL basic_status_done got=%h want=00", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d, e;
        bit ok;
        wr(2'd0, 8'h0F);
        sb.push_back(8'h84);
        sb.push_back(8'h8C);
        pulse_irq(4'b1010);
        for (int k = 0; k < 2; k++) begin
            wait_req(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL prio_req%0d got=timeout want=int_req", k); end
            else begin
                e = sb.pop_front();
                checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL prio_vec%0d got=%h want=%h", k, bus.int_vector, e); end
            end
            pulse_ack();
            pulse_done();
        end
        rd(2'd1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL prio_pending got=%h want=00", d); end
    endtask

    task automatic test_mask_withdraw();
        logic [7:0] d, e;
        bit ok;
        wr(2'd0, 8'h00);
        pulse_irq(4'b0100);
        step(2);
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL mask_noreq got=%b want=0", bus.int_req); end
        rd(2'd1, d);
        checks++; if (d !== 8'h04) begin failures++; $display("FAIL mask_pending got=%h want=04", d); end
        sb.push_back(8'h88);
        wr(2'd0, 8'h04);
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mask_req got=timeout want=int_req"); end
        else begin
            e = sb.pop_front();
            checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL mask_vec got=%h want=%h", bus.int_vector, e); end
        end
        wr(2'd0, 8'h00);
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL withdraw_req got=%b want=0", bus.int_req); end
        rd(2'd2, d);
        checks++; if (d[7:6] !== 2'b00) begin failures++; $display("FAIL withdraw_state got=%b want=00", d[7:6]); end
        rd(2'd1, d);
        checks++; if (d !== 8'h04) begin failures++; $display("FAIL withdraw_pending got=%h want=04", d); end
        wr(2'd1, 8'h04);
    endtask

    task automatic test_set_beats_clear();
        logic [7:0] d, e;
        bit ok;
        bus.irq_in[1] = 1'b1;
        wr(2'd1, 8'h02);
        bus.irq_in[1] = 1'b0;
        rd(2'd1, d);
        checks++; if (d !== 8'h02) begin failures++; $display("FAIL sbc_pending got=%h want=02", d); end
        wr(2'd1, 8'h02);
        rd(2'd1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL w1c_pending got=%h want=00", d); end
        rd(2'd3, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL swtrig_read got=%h want=00", d); end
        wr(2'd0, 8'h01);
        sb.push_back(8'h80);
        wr(2'd3, 8'h01);
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL swtrig_req got=timeout want=int_req"); end
        else begin
            e = sb.pop_front();
            checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL swtrig_vec got=%h want=%h", bus.int_vector, e); end
        end
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_reentry();
        logic [7:0] d, e;
        bit ok;
        sb.push_back(8'h80);
        wr(2'd3, 8'h01);
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reent_req got=timeout want=int_req"); end
        else void'(sb.pop_front());
        pulse_ack();
        bus.irq_in[0] = 1'b1; bus.int_ack = 1'b1;
        step();
        bus.irq_in[0] = 1'b0; bus.int_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL reent_noreq%0d got=%b want=0", k, bus.int_req); end
            step();
        end
        rd(2'd2, d);
        checks++; if (d !== 8'h80) begin failures++; $display("FAIL reent_status got=%h want=80", d); end
        rd(2'd1, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL reent_pending got=%h want=01", d); end
        sb.push_back(8'h80);
        pulse_done();
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL reent_done_gap got=%b want=0", bus.int_req); end
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL reent_again got=timeout want=int_req"); end
        else begin
            e = sb.pop_front();
            checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL reent_vec got=%h want=%h", bus.int_vector, e); end
        end
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_reset_mid_request();
        logic [7:0] d, e;
        bit ok;
        wr(2'd0, 8'h04);
        sb.push_back(8'h88);
        pulse_irq(4'b0100);
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_mid_req got=timeout want=int_req"); end
        else begin
            e = sb.pop_front();
            checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL rst_mid_vec got=%h want=%h", bus.int_vector, e); end
        end
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL rst_mid_int_req got=%b want=0", bus.int_req); end
        checks++; if (bus.int_vector !== 8'h80) begin failures++; $display("FAIL rst_mid_vec_reset got=%h want=80", bus.int_vector); end
        rd(2'd1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_mid_pending got=%h want=00", d); end
        rd(2'd0, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_mid_enable got=%h want=00", d); end
        step(3);
        wr(2'd0, 8'h04);
        step(3);
        checks++; if (bus.int_req !== 1'b0) begin failures++; $display("FAIL rst_mid_stale got=%b want=0", bus.int_req); end
        sb.push_back(8'h88);
        pulse_irq(4'b0100);
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_mid_new got=timeout want=int_req"); end
        else begin
            e = sb.pop_front();
            checks++; if (bus.int_vector !== e) begin failures++; $display("FAIL rst_mid_new_vec got=%h want=%h", bus.int_vector, e); end
        end
        pulse_ack();
        pulse_done();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    endtask

    initial begin
        bus.irq_in = '0; bus.int_ack = 1'b0; bus.int_done = 1'b0;
        bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_withdraw();
        test_set_beats_clear();
        test_reentry();
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Requester end of the CPU interrupt handshake. It collects edge-triggered interrupt sources and masks them, then drives int_req and a vector into cpu_top. It holds int_req until the core's int_ack, then waits for the end-of-service pulse the core emits on RETI. It sits between peripherals (PWM channels, timers, software triggers) and cpu_top, and is programmed through a small register port.

Parameters:
NUM_SOURCES, 4, number of interrupt inputs (1..8)
VECTOR_BASE, 8'h80, ISR address for source 0
VECTOR_STRIDE, 8'h04, address distance between consecutive source vectors

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq_in  input  NUM_SOURCES  source lines, rising-edge sensitive, synchronous to clk
int_req  output  1  interrupt request to core
int_vector  output  8  ISR address for the active source; valid while int_req=1
int_ack  input  1  one-cycle pulse: core has accepted the request
int_done  input  1  one-cycle pulse: core executed RETI
reg_we  input  1  register write strobe
reg_addr  input  2  register select
reg_wdata  input  8  write data
reg_rdata  output  8  read data, combinational from reg_addr

Behaviour:
- Reset, on the clk edge with reset=1:
  - state=IDLE, int_req=0, int_vector=VECTOR_BASE.
  - enable, pending, irq_prev, active_id all 0.
  - A reset mid-request or mid-service aborts it with no further int_req.
- Edge detect: rise = irq_in & ~irq_prev. irq_prev is registered every cycle. Level-high sources do not retrigger.
- Pending update, per bit each cycle: set if rise, or if software-trigger write with wdata bit=1. Else clear if W1C write with wdata bit=1, or on ack clear of active_id. Else hold. Set beats clear in the same cycle.
- Candidate = pending & enable. Fixed priority: lowest index wins. Bits at or above NUM_SOURCES read 0 and ignore writes.
- Register map:
  - addr0: enable, R/W.
  - addr1: pending, read; write-1-to-clear.
  - addr2: status, read-only = {in_service, req_active, 3'b0, active_id[2:0]}.
  - addr3: software trigger, write-1-to-set pending; reads 0.
- State machine (registered outputs):
  - IDLE: int_req=0. If candidate≠0: latch active_id = lowest set bit and int_vector = VECTOR_BASE + active_id*VECTOR_STRIDE (8-bit wrap). Next state REQUEST, int_req=1 the following cycle.
  - REQUEST: int_req=1, active_id and int_vector frozen; no preemption by higher-priority arrivals.
    - int_ack=1: clear pending[active_id], go to IN_SERVICE, int_req=0 next cycle.
    - Else if pending[active_id] or enable[active_id] drops (software clear or mask): withdraw, go to IDLE, int_req=0 next cycle.
    - int_ack in the same cycle as a withdraw: ack wins.
  - IN_SERVICE: int_req=0. int_done=1 goes to IDLE; new arbitration on the next cycle. No nesting.
- int_ack outside REQUEST is ignored. int_done outside IN_SERVICE is ignored.
- Latency:
  - irq_in rises in cycle n → pending set at edge n+1 → int_req high after edge n+2.
  - int_ack at cycle m → int_req low after edge m+1.
  - int_done at cycle k → next int_req no earlier than after edge k+2.
- A source edge arriving while the same source is in service re-sets pending. It is serviced after int_done.

Test Plan:
- Basic handshake: enable=4'b0001, pulse irq_in[0] → int_req=1 two cycles later with int_vector=8'h80. int_ack pulse → int_req=0 next cycle, status=8'h80. int_done → status=8'h00.
- Priority: enable=4'hF, raise irq_in[3] and irq_in[1] in the same cycle → vector 8'h84 first. After ack/done, second request with vector 8'h8C. pending=4'b0000 at the end.
- Masking and withdraw: enable=0, raise irq_in[2] → pending=4'b0100, int_req stays 0. Write enable=4'b0100 → int_req=1, vector 8'h88. Write enable=0 before ack → int_req=0 next cycle, state IDLE, pending still 4'b0100.
- Set-beats-clear: W1C pending bit 1 in the same cycle as an irq_in[1] rising edge → pending[1]=1. Software trigger write 8'h01 → request with vector 8'h80.
- Re-entry and ignored strobes: during IN_SERVICE of source 0, pulse irq_in[0] and int_ack → no int_req while in service. After int_done, int_req=1 again with 8'h80.
- Reset mid-request: int_req=1 (source 2), assert reset one cycle → int_req=0, int_vector=8'h80, pending=0, enable=0. No request after reset until enable is re-written and a new edge arrives.
